// File: rtl/fetch_stage.sv
// Instruction-fetch stage: next-PC generation, SRAM-like instruction port,
// one-entry instruction buffer for ID stalls, and branch-redirect squashing.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [33:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;
  logic [31:0] br_buf_target_q, br_buf_target_d;
  logic        br_buf_valid_q, br_buf_valid_d;
  logic        discard_q, discard_d;

  logic        br_taken_cancel;
  logic [31:0] br_target;
  logic        unused_br_taken;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        fs_ready_go;
  logic        cancel_pending;
  logic        fs_allowin;
  logic        fetch_accept;
  logic        ds_takes_inst;
  logic        buf_load;

  assign br_taken_cancel = br_bus[33];
  assign unused_br_taken = br_bus[32];
  assign br_target       = br_bus[31:0];

  assign seq_pc = fs_pc_q + 32'd4;

  // Reset forces the reset vector so the address bus is defined while held.
  always_comb begin
    nextpc = seq_pc;
    if (reset) begin
      nextpc = RESET_PC;
    end else if (br_taken_cancel) begin
      nextpc = br_target;
    end else if (br_buf_valid_q) begin
      nextpc = br_buf_target_q;
    end
  end

  assign fs_ready_go    = inst_buf_valid_q | (inst_sram_data_ok & ~discard_q);
  assign cancel_pending = br_taken_cancel & fs_valid_q & ~fs_ready_go;
  assign fs_allowin     = ~fs_valid_q
                        | (fs_ready_go & ds_allowin)
                        | (br_taken_cancel & fs_ready_go);

  assign inst_sram_req   = ~reset & fs_allowin & ~discard_q & ~cancel_pending;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;

  assign fetch_accept = inst_sram_req & inst_sram_addr_ok;

  assign fs_to_ds_valid = ~reset & fs_valid_q & fs_ready_go & ~br_taken_cancel;
  assign fs_to_ds_bus   = {(inst_buf_valid_q ? inst_buf_q : inst_sram_rdata), fs_pc_q};

  assign ds_takes_inst = fs_to_ds_valid & ds_allowin;
  assign buf_load      = inst_sram_data_ok & ~discard_q & fs_valid_q
                       & ~ds_allowin & ~br_taken_cancel;

  always_comb begin
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    inst_buf_d       = inst_buf_q;
    inst_buf_valid_d = inst_buf_valid_q;
    br_buf_target_d  = br_buf_target_q;
    br_buf_valid_d   = br_buf_valid_q;
    discard_d        = discard_q;

    if (fetch_accept) begin
      fs_valid_d = 1'b1;
      fs_pc_d    = nextpc;
    end else if (fs_allowin || cancel_pending) begin
      fs_valid_d = 1'b0;
    end

    // A redirect that could not be issued this cycle is remembered until accepted.
    if (fetch_accept) begin
      br_buf_valid_d = 1'b0;
    end else if (br_taken_cancel) begin
      br_buf_valid_d  = 1'b1;
      br_buf_target_d = br_target;
    end

    if (cancel_pending) begin
      discard_d = 1'b1;
    end else if (discard_q && inst_sram_data_ok) begin
      discard_d = 1'b0;
    end

    if (br_taken_cancel || ds_takes_inst) begin
      inst_buf_valid_d = 1'b0;
    end else if (buf_load) begin
      inst_buf_valid_d = 1'b1;
      inst_buf_d       = inst_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      inst_buf_q       <= 32'h0000_0000;
      inst_buf_valid_q <= 1'b0;
      br_buf_target_q  <= 32'h0000_0000;
      br_buf_valid_q   <= 1'b0;
      discard_q        <= 1'b0;
    end else begin
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      inst_buf_q       <= inst_buf_d;
      inst_buf_valid_q <= inst_buf_valid_d;
      br_buf_target_q  <= br_buf_target_d;
      br_buf_valid_q   <= br_buf_valid_d;
      discard_q        <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized traffic,
// checked against a program-order stream model and a behavioural memory.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h1C000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic [33:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .reset             (reset),
    .ds_allowin        (ds_allowin),
    .br_bus            (br_bus),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural memory: at most one pending read, returned after pend_wait idle cycles.
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_wait;
  int          next_lat;
  logic        hash_mode;

  // Program-order stream model: the PC ID must see next.
  logic [31:0] exp_pc;
  int          idle_cycles;
  logic        hold_valid;
  logic [63:0] hold_bus;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (hash_mode) return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
    return a;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic allow, input logic cancel, input logic [31:0] tgt,
                               input logic aok, input int lat);
    ds_allowin        = allow;
    br_bus            = {cancel, cancel, tgt};
    inst_sram_addr_ok = aok;
    next_lat          = lat;
    inst_sram_data_ok = pend && (pend_wait == 0);
    inst_sram_rdata   = inst_sram_data_ok ? mem_word(pend_addr) : $urandom();
    #4;
  endtask

  task automatic endCycle;
    logic        acc;
    logic        dok;
    logic        cancel;
    logic [31:0] aaddr;
    logic [63:0] bus;
    acc    = inst_sram_req & inst_sram_addr_ok;
    aaddr  = inst_sram_addr;
    dok    = inst_sram_data_ok;
    cancel = br_bus[33];
    bus    = fs_to_ds_bus;

    if (reset) begin
      checkOutput("reset_req", inst_sram_req, 0);
      checkOutput("reset_fwd", fs_to_ds_valid, 0);
      exp_pc      = RESET_PC;
      idle_cycles = 0;
    end else begin
      checkOutput("one_outstanding", inst_sram_req & pend & ~dok, 0);
      if (hold_valid && !cancel) begin
        checkOutput("stall_hold_valid", fs_to_ds_valid, 1);
        checkOutput("stall_hold_bus", bus, hold_bus);
      end
      if (cancel) begin
        checkOutput("no_fwd_on_cancel", fs_to_ds_valid, 0);
        exp_pc = br_bus[31:0];
        idle_cycles++;
      end else if (fs_to_ds_valid && ds_allowin) begin
        checkOutput("stream_pc", bus[31:0], exp_pc);
        checkOutput("stream_inst", bus[63:32], mem_word(exp_pc));
        exp_pc      = exp_pc + 32'd4;
        idle_cycles = 0;
      end else begin
        idle_cycles++;
      end
    end
    hold_valid = !reset && !cancel && fs_to_ds_valid && !ds_allowin;
    hold_bus   = bus;

    @(posedge clk);
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (dok) pend = 1'b0;
      else if (pend) pend_wait--;
      if (acc) begin
        pend      = 1'b1;
        pend_addr = aaddr;
        pend_wait = next_lat;
      end
    end
    #1;
  endtask

  initial begin
    logic        r_allow;
    logic        r_cancel;
    logic [31:0] r_tgt;
    reset       = 1'b1;
    pend        = 1'b0;
    pend_addr   = '0;
    pend_wait   = 0;
    hash_mode   = 1'b0;
    hold_valid  = 1'b0;
    hold_bus    = '0;
    exp_pc      = RESET_PC;
    idle_cycles = 0;

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 1, 0);
      checkOutput("reset_addr", inst_sram_addr, RESET_PC);
      endCycle();
    end
    checkOutput("const_ports", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
                {1'b0, 2'b10, 4'b0000, 32'h0});

    // Streaming from the reset vector with a zero-wait memory.
    reset = 1'b0;
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("c0_req", inst_sram_req, 1);
    checkOutput("c0_addr", inst_sram_addr, RESET_PC);
    endCycle();
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("c1_valid", fs_to_ds_valid, 1);
    checkOutput("c1_bus", fs_to_ds_bus, {RESET_PC, RESET_PC});
    checkOutput("c1_addr", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1C000004});
    endCycle();

    // ID stalls for three cycles while 0x1C000004 returns.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("stall_valid", fs_to_ds_valid, 1);
      checkOutput("stall_bus", fs_to_ds_bus, {32'h1C000004, 32'h1C000004});
      checkOutput("stall_req", inst_sram_req, 0);
      endCycle();
    end
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("release_bus", {fs_to_ds_valid, fs_to_ds_bus}, {1'b1, 32'h1C000004, 32'h1C000004});
    checkOutput("release_addr", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1C000008});
    endCycle();

    // Cancel in the cycle 0x1C000008 returns.
    applyStimulus(1, 1, 32'h1C000100, 1, 0);
    checkOutput("br1_fwd", fs_to_ds_valid, 0);
    checkOutput("br1_addr", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1C000100});
    endCycle();
    applyStimulus(1, 0, 0, 1, 3);
    checkOutput("br1_target_bus", {fs_to_ds_valid, fs_to_ds_bus}, {1'b1, 32'h1C000100, 32'h1C000100});
    checkOutput("br1_next_addr", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1C000104});
    endCycle();

    // Cancel while 0x1C000104 is outstanding; its late data must be dropped.
    applyStimulus(1, 1, 32'h1C000200, 1, 0);
    checkOutput("br2_req", inst_sram_req, 0);
    checkOutput("br2_fwd", fs_to_ds_valid, 0);
    endCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 1, 0);
      checkOutput("br2_wait_req", inst_sram_req, 0);
      checkOutput("br2_wait_fwd", fs_to_ds_valid, 0);
      endCycle();
    end
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("br2_resume", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1C000200});
    endCycle();
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("br2_target_bus", {fs_to_ds_valid, fs_to_ds_bus}, {1'b1, 32'h1C000200, 32'h1C000200});
    endCycle();

    // Cancel whose target request is refused for two cycles.
    applyStimulus(1, 1, 32'h1C000300, 0, 0);
    checkOutput("br3_addr0", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1C000300});
    endCycle();
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("br3_addr1", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1C000300});
    endCycle();
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("br3_addr2", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1C000300});
    endCycle();
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("br3_target_bus", {fs_to_ds_valid, fs_to_ds_bus}, {1'b1, 32'h1C000300, 32'h1C000300});
    checkOutput("br3_seq_addr", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1C000304});
    endCycle();

    // Buffer 0x1C000304, then reset on top of it.
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("pre_reset_req", inst_sram_req, 0);
    endCycle();
    reset     = 1'b1;
    hash_mode = 1'b1;
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("mid_reset_addr", inst_sram_addr, RESET_PC);
    endCycle();
    reset = 1'b0;
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("restart_addr", {inst_sram_req, inst_sram_addr}, {1'b1, RESET_PC});
    endCycle();
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("restart_bus", {fs_to_ds_valid, fs_to_ds_bus}, {1'b1, mem_word(RESET_PC), RESET_PC});
    endCycle();

    // Random traffic, including redirects near the top of the address space.
    for (int i = 0; i < 4000; i++) begin
      r_allow  = ($urandom_range(0, 3) != 0);
      r_cancel = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) r_tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else r_tgt = RESET_PC + 32'($urandom_range(0, 1023) * 4);
      applyStimulus(r_allow, r_cancel, r_tgt, ($urandom_range(0, 3) != 0), $urandom_range(0, 3));
      br_bus[32] = 1'($urandom_range(0, 1));
      endCycle();
      if (idle_cycles > 200) begin
        checkOutput("progress_timeout", 64'(idle_cycles), 0);
        break;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
